// File: rtl/hazard_control_unit_if.sv
// Hazard control bundle: ID/EX hazard inputs from the pipeline, hold/flush controls back to it.
interface hazard_control_unit_if #(
   parameter int unsigned CNT_W = 16
) ();

   logic [4:0]       rs1_address_id_i;
   logic [4:0]       rs2_address_id_i;
   logic             rs1_in_use_i;
   logic             rs2_in_use_i;
   logic [4:0]       rd_address_ex_i;
   logic             mem_read_ex_i;
   logic             branch_taken_ex_i;
   logic             mdu_start_i;
   logic             mdu_done_i;

   logic             pc_en_o;
   logic             if_id_en_o;
   logic             stall_o;
   logic             id_ex_flush_o;
   logic             if_id_flush_o;
   logic             mdu_timeout_o;
   logic [CNT_W-1:0] stall_cycles_o;

   // Pipeline side: drives hazard sources, consumes controls.
   modport master (
      output rs1_address_id_i, rs2_address_id_i, rs1_in_use_i, rs2_in_use_i,
      output rd_address_ex_i, mem_read_ex_i, branch_taken_ex_i,
      output mdu_start_i, mdu_done_i,
      input  pc_en_o, if_id_en_o, stall_o, id_ex_flush_o, if_id_flush_o,
      input  mdu_timeout_o, stall_cycles_o
   );

   // Hazard unit side.
   modport slave (
      input  rs1_address_id_i, rs2_address_id_i, rs1_in_use_i, rs2_in_use_i,
      input  rd_address_ex_i, mem_read_ex_i, branch_taken_ex_i,
      input  mdu_start_i, mdu_done_i,
      output pc_en_o, if_id_en_o, stall_o, id_ex_flush_o, if_id_flush_o,
      output mdu_timeout_o, stall_cycles_o
   );

endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hold/flush generation: load-use bubbles, branch squash, multi-cycle MDU
// sequencing with a watchdog, and a saturating stall-cycle counter.
module hazard_control_unit #(
   parameter int unsigned MDU_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   hazard_control_unit_if.slave  hcu
);

   localparam int unsigned       TO_W    = $clog2(MDU_TIMEOUT) + 1;
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(MDU_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   typedef enum logic [0:0] {
      ST_RUN,
      ST_MDU_WAIT
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [TO_W-1:0]   to_cnt_q;
   logic [TO_W-1:0]   to_cnt_d;
   logic              timeout_q;
   logic              timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic              luh_c;
   logic              rs1_hit_c;
   logic              rs2_hit_c;
   logic              pc_en_c;
   logic              if_id_en_c;
   logic              stall_c;
   logic              id_ex_flush_c;
   logic              if_id_flush_c;

   // A load writing x0 never creates a real dependency.
   assign rs1_hit_c = hcu.rs1_in_use_i && (hcu.rs1_address_id_i == hcu.rd_address_ex_i);
   assign rs2_hit_c = hcu.rs2_in_use_i && (hcu.rs2_address_id_i == hcu.rd_address_ex_i);
   assign luh_c     = hcu.mem_read_ex_i && (hcu.rd_address_ex_i != 5'd0) && (rs1_hit_c || rs2_hit_c);

   // State, watchdog, sticky error and performance counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         to_cnt_q    <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
         if (!pc_en_c && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
      end
   end

   // Next state and Mealy controls; everything is held low while in reset.
   always_comb begin
      state_d       = state_q;
      to_cnt_d      = to_cnt_q;
      timeout_d     = timeout_q;
      pc_en_c       = 1'b0;
      if_id_en_c    = 1'b0;
      stall_c       = 1'b0;
      id_ex_flush_c = 1'b0;
      if_id_flush_c = 1'b0;

      if (reset) begin
         case (state_q)
            ST_RUN: begin
               if (hcu.branch_taken_ex_i) begin
                  // The ID instruction is squashed, so any load-use on it is moot.
                  pc_en_c       = 1'b1;
                  if_id_en_c    = 1'b1;
                  stall_c       = 1'b1;
                  id_ex_flush_c = 1'b1;
                  if_id_flush_c = 1'b1;
               end else if (hcu.mdu_start_i) begin
                  if (hcu.mdu_done_i) begin
                     pc_en_c    = 1'b1;
                     if_id_en_c = 1'b1;
                     stall_c    = 1'b1;
                  end else begin
                     state_d  = ST_MDU_WAIT;
                     to_cnt_d = '0;
                  end
               end else if (luh_c) begin
                  stall_c       = 1'b1;
                  id_ex_flush_c = 1'b1;
               end else begin
                  pc_en_c    = 1'b1;
                  if_id_en_c = 1'b1;
                  stall_c    = 1'b1;
               end
            end

            ST_MDU_WAIT: begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (hcu.mdu_done_i) begin
                  pc_en_c    = 1'b1;
                  if_id_en_c = 1'b1;
                  stall_c    = 1'b1;
                  state_d    = ST_RUN;
               end else if (to_cnt_q == TO_LAST) begin
                  // Watchdog: release the pipeline and latch the error.
                  pc_en_c    = 1'b1;
                  if_id_en_c = 1'b1;
                  stall_c    = 1'b1;
                  timeout_d  = 1'b1;
                  state_d    = ST_RUN;
               end
            end

            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   assign hcu.pc_en_o        = pc_en_c;
   assign hcu.if_id_en_o     = if_id_en_c;
   assign hcu.stall_o        = stall_c;
   assign hcu.id_ex_flush_o  = id_ex_flush_c;
   assign hcu.if_id_flush_o  = if_id_flush_c;
   assign hcu.mdu_timeout_o  = timeout_q;
   assign hcu.stall_cycles_o = stall_cnt_q;

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Generates the pipeline hold and flush controls consumed by the IF/ID and ID/EX registers and by the forwarding path: pc_en_o, if_id_en_o, stall_o and the flush outputs.
- Detects load-use hazards and taken-branch redirects.
- Sequences multi-cycle M-extension (div/rem) operations held in EX through a small FSM with a timeout watchdog.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MDU_TIMEOUT, 64: maximum MDU_WAIT cycles before forced release.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-low.
- rs1_address_id_i, input, 5: rs1 of the instruction in ID.
- rs2_address_id_i, input, 5: rs2 of the instruction in ID.
- rs1_in_use_i, input, 1: the ID instruction reads rs1.
- rs2_in_use_i, input, 1: the ID instruction reads rs2.
- rd_address_ex_i, input, 5: rd of the instruction in EX.
- mem_read_ex_i, input, 1: the EX instruction is a load.
- branch_taken_ex_i, input, 1: a branch or jump resolved taken in EX.
- mdu_start_i, input, 1: a multi-cycle M op entered EX this cycle.
- mdu_done_i, input, 1: the MDU result is valid this cycle.
- pc_en_o, output, 1: PC update enable.
- if_id_en_o, output, 1: IF/ID register enable.
- stall_o, output, 1: ID/EX and EX/MEM advance enable. Active-low hold: 1 = advance, 0 = hold.
- id_ex_flush_o, output, 1: insert a bubble into ID/EX.
- if_id_flush_o, output, 1: squash IF/ID.
- mdu_timeout_o, output, 1: sticky watchdog error flag.
- stall_cycles_o, output, CNT_W: saturating count of cycles with pc_en_o=0.

Behaviour:
- Reset: clk and reset (synchronous, active-low) are fixed.
  - While reset=0: state=RUN, timeout counter=0, mdu_timeout_o=0, stall_cycles_o=0.
  - Combinational outputs are forced during reset: pc_en_o=0, if_id_en_o=0, stall_o=0, both flushes=0.
  - The first cycle after reset=1 follows normal RUN rules.
- States: RUN, MDU_WAIT. All outputs are Mealy (state + current inputs), zero latency.
- Load-use hazard: luh = mem_read_ex_i && rd_address_ex_i!=0 && ((rs1_in_use_i && rs1_address_id_i==rd_address_ex_i) || (rs2_in_use_i && rs2_address_id_i==rd_address_ex_i)).
- RUN, outputs by priority (highest first):
  1. branch_taken_ex_i=1: if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1, if_id_en_o=1, stall_o=1. luh is ignored, because the ID instruction is squashed.
  2. mdu_start_i=1: pc_en_o=0, if_id_en_o=0, stall_o=0, no flush. Next state is MDU_WAIT with timeout counter cleared, unless mdu_done_i=1 in the same cycle; in that case stall_o=1, pc_en_o=1, if_id_en_o=1 and the state stays RUN.
  3. luh=1: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, stall_o=1. Exactly one bubble; the next cycle re-evaluates, so luh is normally 0 by then.
  4. Otherwise: pc_en_o=1, if_id_en_o=1, stall_o=1, flushes=0.
- mdu_start_i and mem_read_ex_i both high cannot occur legally; if they do, the MDU rule wins.
- MDU_WAIT:
  - Hold: pc_en_o=0, if_id_en_o=0, stall_o=0, flushes=0. branch_taken_ex_i and luh are ignored.
  - Timeout counter increments each cycle.
  - mdu_done_i=1: release that cycle (pc_en_o=1, if_id_en_o=1, stall_o=1), next state RUN. luh is not evaluated in the release cycle.
  - Counter reaches MDU_TIMEOUT-1 with no done: release the same way, set mdu_timeout_o=1 (sticky until reset), next state RUN.
  - mdu_start_i while in MDU_WAIT is ignored.
- stall_cycles_o increments by 1 on each clock edge where pc_en_o=0 and reset=1. It saturates at all-ones (no wrap).
- Reset asserted mid-MDU_WAIT returns the block to RUN on the next edge; a later mdu_done_i while in RUN is ignored.

Test Plan:
- Load-use: rd_address_ex=5, mem_read_ex=1, rs1_id=5, rs1_in_use=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, stall=1 for 1 cycle; stall_cycles 0->1.
- x0 / unused operand:
  - rd_address_ex=0 with rs1_id=0 and load in EX -> no stall.
  - rs2 match with rs2_in_use=0 -> no stall.
- Branch over load-use: luh=1 and branch_taken_ex=1 together -> both flushes=1, pc_en=1, id_ex_flush=1, counter unchanged.
- MDU: mdu_start=1, mdu_done after 33 cycles -> stall=0, pc_en=0 for 33 cycles; release on the done cycle; stall_cycles=33; mdu_timeout=0.
- Timeout: MDU_TIMEOUT=8, mdu_start with no done -> release after 8 held cycles, mdu_timeout=1 and remains 1 through further traffic until reset=0.
- Reset mid-wait / saturation:
  - reset=0 during MDU_WAIT -> outputs forced low, RUN afterwards.
  - CNT_W=4, 20 stall cycles -> stall_cycles_o=15.
